// File: rtl/mapped_memory_pkg.sv
// Shared types and constants for the mapped memory unit: FSM states, display
// control offsets (relative to the start of the control window) and byte-lane geometry.
package mapped_memory_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

    // Control window starts at offset DISP_BYTES; these are added to that base.
    localparam int DISP_COMMIT_OFS = 0;
    localparam int DISP_CLEAR_OFS  = 4;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

endpackage

// File: rtl/display_bank.sv
// Byte-addressed display store with write, clear-index and registered read ports.
// Define DISP_DOUBLE_BUFFER_EN to show a front copy that is reloaded from the back buffer on commit.
module display_bank
    import mapped_memory_pkg::*;
#(
    parameter int DISP_BYTES = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [$clog2(DISP_BYTES)-1:0]  wr_idx,
    input  logic [LANE_W-1:0]              wr_data,
    input  logic                           clr_en,
    input  logic [$clog2(DISP_BYTES)-1:0]  clr_idx,
    input  logic                           commit,
    input  logic [$clog2(DISP_BYTES)-1:0]  rd_idx,
    output logic [LANE_W-1:0]              rd_data,
    output logic [8*DISP_BYTES-1:0]        display_buffer
);
    localparam int BW = $clog2(DISP_BYTES);

    logic [8*DISP_BYTES-1:0] back_flat;

    generate
        for (genvar gi = 0; gi < DISP_BYTES; gi++) begin : g_byte
            localparam logic [BW-1:0] IDX = BW'(gi);
            logic [LANE_W-1:0] back_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    back_reg <= '0;
                end else if (clr_en && clr_idx == IDX) begin
                    back_reg <= '0;
                end else if (wr_en && wr_idx == IDX) begin
                    back_reg <= wr_data;
                end
            end

            assign back_flat[8*gi +: 8] = back_reg;

`ifdef DISP_DOUBLE_BUFFER_EN
            logic [LANE_W-1:0] front_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    front_reg <= '0;
                end else if (commit) begin
                    front_reg <= back_reg;
                end
            end

            // Byte 0 sits in the most significant lane of the flattened bus.
            assign display_buffer[8*(DISP_BYTES-gi)-1 -: 8] = front_reg;
`else
            assign display_buffer[8*(DISP_BYTES-gi)-1 -: 8] = back_reg;
`endif
        end
    endgenerate

`ifndef DISP_DOUBLE_BUFFER_EN
    logic unused_commit;
    assign unused_commit = commit;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= back_flat[{rd_idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/mapped_memory_unit.sv
// Unified instruction/data memory with a memory-mapped display buffer and a clear FSM.
// Optional DISP_DOUBLE_BUFFER_EN selects a committed front copy for the display output.
module mapped_memory_unit
    import mapped_memory_pkg::*;
#(
    parameter int    MEM_DEPTH_WORDS = 1024,
    parameter int    DISP_BYTES      = 32,
    parameter string INIT_FILE       = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             i_addr,
    output logic [31:0]             i_data,
    input  logic                    d_req,
    output logic                    d_ready,
    input  logic                    d_we,
    input  logic [3:0]              d_be,
    input  logic                    d_type,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_rvalid,
    output logic [31:0]             d_rdata,
    output logic                    d_err,
    output logic [8*DISP_BYTES-1:0] display_buffer
);
    localparam int AW = $clog2(MEM_DEPTH_WORDS);
    localparam int BW = $clog2(DISP_BYTES);
    localparam int OW = BW + 1;
    localparam logic [29:0]   DEPTH_W    = 30'(MEM_DEPTH_WORDS);
    localparam logic [BW-1:0] COMMIT_IDX = BW'(DISP_COMMIT_OFS);
    localparam logic [BW-1:0] CLEAR_IDX  = BW'(DISP_CLEAR_OFS);
    localparam logic [BW-1:0] LAST_IDX   = BW'(DISP_BYTES - 1);
    // With the smallest display the clear offset aliases back into byte space.
    localparam bit CLEAR_REACHABLE = (DISP_CLEAR_OFS < DISP_BYTES);

    logic [31:0] mem [MEM_DEPTH_WORDS];

    fsm_state_t      state_reg, state_next;
    logic [BW-1:0]   clr_idx_reg;
    logic            clr_en;
    logic            rvalid_reg, err_reg, rd_main_reg, rd_disp_reg;
    logic [31:0]     i_data_reg, d_word_reg;
    logic [7:0]      disp_rd;

    logic            accept, main_err, disp_err, req_err;
    logic            ctl_region, is_commit, is_clear;
    logic [BW-1:0]   ctl_idx;
    logic [AW-1:0]   widx;
    logic            main_wr, disp_wr, disp_commit, clear_start;

    always_comb begin
        widx        = d_addr[2 +: AW];
        main_err    = (d_addr[1:0] != 2'b00) || (d_addr[31:2] >= DEPTH_W);
        ctl_region  = d_addr[OW-1];
        ctl_idx     = d_addr[BW-1:0];
        is_commit   = ctl_region && (ctl_idx == COMMIT_IDX);
        is_clear    = ctl_region && CLEAR_REACHABLE && (ctl_idx == CLEAR_IDX);
        disp_err    = ctl_region && !(d_we && (is_commit || is_clear));
        req_err     = d_type ? disp_err : main_err;
        accept      = d_req && d_ready && !reset;
        main_wr     = accept && d_we && !d_type && !main_err;
        disp_wr     = accept && d_we && d_type && !ctl_region;
        disp_commit = accept && d_we && d_type && is_commit;
        clear_start = accept && d_we && d_type && is_clear;
    end

    // Main RAM: byte-lane writes with read-first registered reads on both ports.
    always_ff @(posedge clk) begin
        if (main_wr) begin
            for (int l = 0; l < LANES; l++) begin
                if (d_be[l]) begin
                    mem[widx][LANE_W*l +: LANE_W] <= d_wdata[LANE_W*l +: LANE_W];
                end
            end
        end
        d_word_reg <= mem[widx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_data_reg <= '0;
        end else begin
            i_data_reg <= mem[i_addr[2 +: AW]];
        end
    end

    logic unused_iaddr;
    assign unused_iaddr = ^{i_addr[31:AW+2], i_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (clear_start) state_next = CLEAR;
            CLEAR:   if (clr_idx_reg == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        d_ready = (state_reg == IDLE);
        clr_en  = (state_reg == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset || state_reg == IDLE) begin
            clr_idx_reg <= '0;
        end else begin
            clr_idx_reg <= clr_idx_reg + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_reg  <= 1'b0;
            err_reg     <= 1'b0;
            rd_main_reg <= 1'b0;
            rd_disp_reg <= 1'b0;
        end else begin
            rvalid_reg  <= accept;
            err_reg     <= accept && req_err;
            rd_main_reg <= accept && !d_we && !d_type && !req_err;
            rd_disp_reg <= accept && !d_we && d_type && !req_err;
        end
    end

    display_bank #(
        .DISP_BYTES(DISP_BYTES)
    ) u_display_bank (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (disp_wr),
        .wr_idx        (ctl_idx),
        .wr_data       (d_wdata[7:0]),
        .clr_en        (clr_en),
        .clr_idx       (clr_idx_reg),
        .commit        (disp_commit),
        .rd_idx        (ctl_idx),
        .rd_data       (disp_rd),
        .display_buffer(display_buffer)
    );

    assign i_data   = i_data_reg;
    assign d_rvalid = rvalid_reg;
    assign d_err    = err_reg;
    assign d_rdata  = rd_main_reg ? d_word_reg :
                      rd_disp_reg ? {24'h0, disp_rd} : 32'h0;

endmodule

// File: tb/tb_mapped_memory_unit.sv
// Directed self-checking bench for mapped_memory_unit (single-buffer build).
module tb_mapped_memory_unit;
    localparam int DEPTH = 64;
    localparam int NB    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   i_addr;
    logic [31:0]   i_data;
    logic          d_req, d_ready, d_we, d_type;
    logic [3:0]    d_be;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          d_rvalid, d_err;
    logic [8*NB-1:0] display_buffer;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mapped_memory_unit #(
        .MEM_DEPTH_WORDS(DEPTH),
        .DISP_BYTES(NB),
        .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset), .i_addr(i_addr), .i_data(i_data),
        .d_req(d_req), .d_ready(d_ready), .d_we(d_we), .d_be(d_be),
        .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .display_buffer(display_buffer)
    );

    // One request; called at posedge+1, returns at the next posedge+1 with the response.
    task automatic xact(input logic we, input logic typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic v, output logic [31:0] r, output logic e);
        d_req = 1'b1; d_we = we; d_type = typ; d_addr = addr; d_wdata = wdata; d_be = be;
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
        v = d_rvalid; r = d_rdata; e = d_err;
        $display("xact we=%0d type=%0d addr=%h wdata=%h be=%b -> rvalid=%0d rdata=%h err=%0d",
                 we, typ, addr, wdata, be, v, r, e);
    endtask

    task automatic test_reset();
        reset = 1'b1; d_req = 1'b0; d_we = 1'b0; d_type = 1'b0; d_be = 4'h0;
        d_addr = '0; d_wdata = '0; i_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d_ready !== 1'b1 || d_rvalid !== 1'b0 || d_err !== 1'b0 || d_rdata !== 32'h0 || i_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b err=%b rdata=%h i_data=%h want 1 0 0 0 0",
                     d_ready, d_rvalid, d_err, d_rdata, i_data);
        end
        checks++;
        if (display_buffer !== '0) begin
            errors++;
            $display("FAIL reset_display: got %h want 0", display_buffer);
        end
        reset = 1'b0;
    endtask

    task automatic test_instr();
        logic v, e; logic [31:0] r;
        xact(1'b1, 1'b0, 32'h8, 32'h12345678, 4'hF, v, r, e);
        i_addr = 32'h8;
        @(posedge clk); #1;
        checks++;
        if (i_data !== 32'h12345678) begin
            errors++; $display("FAIL instr_read: got %h want 12345678", i_data);
        end
        i_addr = 4*DEPTH + 8;
        @(posedge clk); #1;
        checks++;
        if (i_data !== 32'h12345678) begin
            errors++; $display("FAIL instr_wrap: got %h want 12345678", i_data);
        end
        // Same-word write and fetch in one cycle: fetch sees the old word.
        i_addr = 32'h8;
        xact(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 4'hF, v, r, e);
        checks++;
        if (i_data !== 32'h12345678) begin
            errors++; $display("FAIL instr_read_first: got %h want 12345678", i_data);
        end
        @(posedge clk); #1;
        checks++;
        if (i_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL instr_after_write: got %h want deadbeef", i_data);
        end
        i_addr = '0;
    endtask

    task automatic test_byte_enable();
        logic v, e; logic [31:0] r;
        xact(1'b1, 1'b0, 32'h40, 32'hAABBCCDD, 4'b1111, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin
            errors++; $display("FAIL write_resp: v=%b e=%b r=%h want 1 0 0", v, e, r);
        end
        xact(1'b1, 1'b0, 32'h40, 32'h11223344, 4'b0101, v, r, e);
        xact(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || r !== 32'hAA22CC44) begin
            errors++; $display("FAIL byte_enable_merge: v=%b e=%b r=%h want 1 0 aa22cc44", v, e, r);
        end
        xact(1'b1, 1'b0, 32'h40, 32'h00000000, 4'b0000, v, r, e);
        xact(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, v, r, e);
        checks++;
        if (r !== 32'hAA22CC44 || e !== 1'b0) begin
            errors++; $display("FAIL be_zero_noop: r=%h e=%b want aa22cc44 0", r, e);
        end
    endtask

    task automatic test_errors();
        logic v, e; logic [31:0] r;
        xact(1'b0, 1'b0, 32'h41, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL misaligned_read: v=%b e=%b r=%h want 1 1 0", v, e, r);
        end
        xact(1'b1, 1'b0, 32'h0, 32'h01020304, 4'hF, v, r, e);
        xact(1'b1, 1'b0, 4*DEPTH, 32'hFFFFFFFF, 4'hF, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1) begin
            errors++; $display("FAIL range_write_err: v=%b e=%b want 1 1", v, e);
        end
        xact(1'b1, 1'b0, 32'h42, 32'hFFFFFFFF, 4'hF, v, r, e);
        xact(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, v, r, e);
        checks++;
        if (r !== 32'h01020304 || e !== 1'b0) begin
            errors++; $display("FAIL range_write_blocked: r=%h e=%b want 01020304 0", r, e);
        end
        xact(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, v, r, e);
        checks++;
        if (r !== 32'hAA22CC44) begin
            errors++; $display("FAIL misaligned_write_blocked: r=%h want aa22cc44", r);
        end
    endtask

    task automatic test_display();
        logic v, e; logic [31:0] r;
        xact(1'b1, 1'b1, 32'h0, 32'h1234565A, 4'h0, v, r, e);
        checks++;
        if (display_buffer[8*NB-1 -: 8] !== 8'h5A || e !== 1'b0) begin
            errors++; $display("FAIL disp_write_byte0: got %h e=%b want 5a 0", display_buffer[8*NB-1 -: 8], e);
        end
        xact(1'b1, 1'b1, 32'd23, 32'h0000ABC3, 4'hF, v, r, e);
        checks++;
        if (display_buffer !== 64'h5A000000000000C3) begin
            errors++; $display("FAIL disp_wrap_byte7: got %h want 5a000000000000c3", display_buffer);
        end
        xact(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || r !== 32'h0000005A) begin
            errors++; $display("FAIL disp_read: v=%b e=%b r=%h want 1 0 0000005a", v, e, r);
        end
        xact(1'b0, 1'b1, NB, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin
            errors++; $display("FAIL ctl_read_err: v=%b e=%b r=%h want 1 1 0", v, e, r);
        end
        xact(1'b1, 1'b1, NB + 2, 32'h0, 4'h0, v, r, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL ctl_other_err: e=%b want 1", e);
        end
        xact(1'b1, 1'b1, NB, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0 || display_buffer !== 64'h5A000000000000C3) begin
            errors++; $display("FAIL commit_noop: v=%b e=%b disp=%h want 1 0 5a000000000000c3", v, e, display_buffer);
        end
    endtask

    task automatic test_clear();
        logic v, e; logic [31:0] r;
        int cnt, guard;
        for (int k = 0; k < NB; k++) begin
            xact(1'b1, 1'b1, k, 32'h10 + k, 4'h0, v, r, e);
        end
        checks++;
        if (display_buffer !== 64'h1011121314151617) begin
            errors++; $display("FAIL disp_fill: got %h want 1011121314151617", display_buffer);
        end
        xact(1'b1, 1'b1, NB + 4, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b0) begin
            errors++; $display("FAIL clear_resp: v=%b e=%b want 1 0", v, e);
        end
        // Hold a display write while busy; it must never be accepted.
        d_req = 1'b1; d_we = 1'b1; d_type = 1'b1; d_addr = 32'h1; d_wdata = 32'hFF;
        cnt = 0; guard = 0;
        while (d_ready === 1'b0 && guard < 50) begin
            cnt++;
            @(posedge clk); #1;
            guard++;
            checks++;
            if (d_rvalid !== 1'b0) begin
                errors++; $display("FAIL clear_req_ignored: rvalid=%b want 0", d_rvalid);
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if (cnt !== NB) begin
            errors++; $display("FAIL clear_busy_cycles: got %0d want %0d", cnt, NB);
        end
        checks++;
        if (display_buffer !== '0) begin
            errors++; $display("FAIL clear_result: got %h want 0", display_buffer);
        end
    endtask

    task automatic test_back_to_back();
        d_req = 1'b1; d_we = 1'b1; d_type = 1'b0; d_addr = 32'h80; d_wdata = 32'h55AA55AA; d_be = 4'hF;
        @(posedge clk); #1;
        $display("xact b2b write 80 -> rvalid=%0d rdata=%h err=%0d", d_rvalid, d_rdata, d_err);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0) begin
            errors++; $display("FAIL b2b_write: v=%b r=%h e=%b want 1 0 0", d_rvalid, d_rdata, d_err);
        end
        d_we = 1'b0;
        @(posedge clk); #1;
        $display("xact b2b read 80 -> rvalid=%0d rdata=%h err=%0d", d_rvalid, d_rdata, d_err);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h55AA55AA || d_err !== 1'b0) begin
            errors++; $display("FAIL b2b_read: v=%b r=%h e=%b want 1 55aa55aa 0", d_rvalid, d_rdata, d_err);
        end
        d_addr = 32'h41;
        @(posedge clk); #1;
        $display("xact b2b read 41 -> rvalid=%0d rdata=%h err=%0d", d_rvalid, d_rdata, d_err);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b1) begin
            errors++; $display("FAIL b2b_err: v=%b r=%h e=%b want 1 0 1", d_rvalid, d_rdata, d_err);
        end
        d_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: rvalid=%b want 0", d_rvalid);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic v, e; logic [31:0] r;
        xact(1'b1, 1'b1, 32'h3, 32'h99, 4'h0, v, r, e);
        xact(1'b1, 1'b1, NB + 4, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || d_ready !== 1'b0) begin
            errors++; $display("FAIL mid_clear_setup: v=%b ready=%b want 1 0", v, d_ready);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (d_ready !== 1'b1 || d_rvalid !== 1'b0 || display_buffer !== '0) begin
            errors++; $display("FAIL reset_mid_clear: ready=%b rvalid=%b disp=%h want 1 0 0",
                               d_ready, d_rvalid, display_buffer);
        end
        reset = 1'b0;
        xact(1'b0, 1'b0, 32'h80, 32'h0, 4'h0, v, r, e);
        checks++;
        if (v !== 1'b1 || r !== 32'h55AA55AA) begin
            errors++; $display("FAIL ram_kept_after_reset: v=%b r=%h want 1 55aa55aa", v, r);
        end
    endtask

    initial begin
        test_reset();
        test_instr();
        test_byte_enable();
        test_errors();
        test_display();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
